// File: rtl/ifetch_buffer.sv
// ifetch_buffer: single-outstanding instruction fetch with a show-ahead FIFO of {instr, pc, fault} for decode
// Ports: clk/reset (sync, active-high); pc_addr in, pc_advance out (PC stage);
//        imem_req/imem_addr out, imem_ack/imem_rdata in (instruction memory);
//        flush in (redirect); dec_valid/dec_instr/dec_pc/dec_fault out, dec_ready in; fifo_count out.
// Optional IFB_MISALIGN_CHECK_EN: a misaligned PC queues a fault entry and halts fetch until flush.
module ifetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                pc_addr,
    output logic                       pc_advance,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       flush,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [31:0]                dec_instr,
    output logic [31:0]                dec_pc,
    output logic                       dec_fault,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;
    state_t state;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic free, ack_push, flt_push, push, pop;
    assign free = count != CW'(DEPTH);
    assign ack_push = state == REQ && imem_ack && !flush;
    assign push = ack_push || flt_push;
    assign dec_valid = count != '0 && !flush;
    assign pop = dec_valid && dec_ready;
    assign pc_advance = ack_push;
    assign imem_req = state == REQ || state == DROP;
    assign fifo_count = count;
    assign dec_instr = instr_q[rd_ptr];
    assign dec_pc = pc_q[rd_ptr];
`ifdef IFB_MISALIGN_CHECK_EN
    logic [DEPTH-1:0] fault_q;
    assign flt_push = state == IDLE && !flush && free && pc_addr[1:0] != 2'b00;
    assign dec_fault = fault_q[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset)
            fault_q <= '0;
        else if (push)
            fault_q[wr_ptr] <= flt_push;
    end
`else
    assign flt_push = 1'b0;
    assign dec_fault = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            imem_addr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= flt_push ? 32'h0 : imem_rdata;
                pc_q[wr_ptr] <= flt_push ? pc_addr : imem_addr;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push != pop)
                    count <= push ? count + 1'b1 : count - 1'b1;
            end
            case (state)
                IDLE:
                    if (flt_push)
                        state <= HALT;
                    else if (!flush && free) begin
                        imem_addr <= pc_addr;
                        state <= REQ;
                    end
                // a flushed request must still see its ack before the bus is free again
                REQ:  state <= imem_ack ? IDLE : (flush ? DROP : REQ);
                DROP: state <= imem_ack ? IDLE : DROP;
                HALT: state <= flush ? IDLE : HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed and randomized check of ifetch_buffer against a transaction-level queue model
module tb_ifetch_buffer;
    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef IFB_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;
    logic clk, reset, pc_advance, imem_req, imem_ack, flush, dec_valid, dec_ready, dec_fault;
    logic [31:0] pc_addr, imem_addr, imem_rdata, dec_instr, dec_pc;
    logic [CW-1:0] fifo_count;
    int total = 0, bad = 0;
    logic [31:0] pc;
    bit m_busy, m_drop, m_halt;
    logic [31:0] m_addr;
    ent_t q[$];
    logic s_req, s_adv, s_valid, s_fault;
    logic [31:0] s_addr, s_instr, s_pc, s_count;

    ifetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_advance(pc_advance),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_fault(dec_fault), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", n, $time, act, exp);
        end
    endtask

    // one clock: drive inputs, compare at negedge against the model, advance model and PC stage
    task automatic tick(input bit r, input bit a, input bit f, input logic [31:0] d, input logic [31:0] tgt);
        bit free;
        dec_ready = r; imem_ack = a; flush = f; imem_rdata = d; pc_addr = pc;
        #4;
        s_req = imem_req; s_addr = imem_addr; s_adv = pc_advance; s_valid = dec_valid;
        s_instr = dec_instr; s_pc = dec_pc; s_fault = dec_fault; s_count = 32'(fifo_count);
        chk("imem_req", 32'(s_req), 32'(m_busy));
        chk("imem_addr", s_addr, m_addr);
        chk("pc_advance", 32'(s_adv), 32'(m_busy && !m_drop && a && !f));
        chk("dec_valid", 32'(s_valid), 32'(q.size() != 0 && !f));
        chk("fifo_count", s_count, 32'(q.size()));
        if (q.size() != 0) begin
            chk("dec_instr", s_instr, q[0].instr);
            chk("dec_pc", s_pc, q[0].pc);
            chk("dec_fault", 32'(s_fault), 32'(q[0].fault));
        end
        if (f) begin
            q.delete();
            m_halt = 0;
            if (m_busy) begin
                m_drop = !a;
                m_busy = !a;
            end
            pc = tgt;
        end else begin
            free = q.size() < DEPTH;
            if (q.size() != 0 && r) void'(q.pop_front());
            if (m_busy) begin
                if (a) begin
                    if (!m_drop) begin
                        q.push_back({d, m_addr, 1'b0});
                        pc = pc + 4;
                    end
                    m_busy = 0;
                    m_drop = 0;
                end
            end else if (!m_halt && free) begin
                if (MIS && pc[1:0] != 2'b00) begin
                    q.push_back({32'h0, pc, 1'b1});
                    m_halt = 1;
                end else begin
                    m_busy = 1;
                    m_addr = pc;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rlvl;
        logic [31:0] t;
        reset = 1'b1; dec_ready = 0; imem_ack = 0; flush = 0; imem_rdata = 0;
        pc = 32'h0040_0000; pc_addr = pc;
        m_busy = 0; m_drop = 0; m_halt = 0; m_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        // reset state, then zero-wait fetch
        tick(0, 0, 0, 0, 0);
        chk("rst_req", 32'(s_req), 0);
        chk("rst_count", s_count, 0);
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_instr", s_instr, 0);
        chk("rst_pc", s_pc, 0);
        chk("rst_fault", 32'(s_fault), 0);
        tick(0, 1, 0, 32'h8C08_0004, 0);
        chk("zw_req", 32'(s_req), 1);
        chk("zw_adv", 32'(s_adv), 1);
        chk("zw_addr", s_addr, 32'h0040_0000);
        tick(0, 0, 0, 0, 0);
        chk("zw_valid", 32'(s_valid), 1);
        chk("zw_instr", s_instr, 32'h8C08_0004);
        chk("zw_pc", s_pc, 32'h0040_0000);
        // backpressure fills the FIFO
        tick(0, 1, 0, 32'h1111_1111, 0);
        tick(0, 0, 0, 0, 0);
        chk("full_count", s_count, 2);
        chk("full_req", 32'(s_req), 0);
        tick(0, 0, 0, 0, 0);
        chk("full_req2", 32'(s_req), 0);
        tick(1, 0, 0, 0, 0);
        chk("pop0_pc", s_pc, 32'h0040_0000);
        tick(1, 0, 0, 0, 0);
        chk("pop1_pc", s_pc, 32'h0040_0004);
        chk("pop1_instr", s_instr, 32'h1111_1111);
        // fetch resumes, ack after 3 wait cycles
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            chk("wait_req", 32'(s_req), 1);
            chk("wait_addr", s_addr, 32'h0040_0008);
        end
        tick(0, 1, 0, 32'h2222_2222, 0);
        chk("wait_ack_req", 32'(s_req), 1);
        chk("wait_adv", 32'(s_adv), 1);
        // flush in REQ with one entry queued
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 32'h0040_0100);
        chk("fl_count_pre", s_count, 1);
        tick(0, 0, 0, 0, 0);
        chk("drop_count", s_count, 0);
        chk("drop_req", 32'(s_req), 1);
        chk("drop_addr", s_addr, 32'h0040_000C);
        tick(0, 1, 0, 32'hDEAD_BEEF, 0);
        chk("drop_adv", 32'(s_adv), 0);
        tick(0, 0, 0, 0, 0);
        chk("post_drop_req", 32'(s_req), 0);
        tick(0, 1, 0, 32'h3333_3333, 0);
        chk("redir_addr", s_addr, 32'h0040_0100);
        // simultaneous push and pop at count 1
        tick(0, 0, 0, 0, 0);
        tick(1, 1, 0, 32'h4444_4444, 0);
        chk("pp_pc", s_pc, 32'h0040_0100);
        tick(0, 0, 0, 0, 0);
        chk("pp_count", s_count, 1);
        chk("pp_pc2", s_pc, 32'h0040_0104);
        // flush with ack in the same cycle
        tick(0, 1, 1, 32'h5555_5555, 32'h0040_0200);
        chk("flack_adv", 32'(s_adv), 0);
        tick(0, 0, 0, 0, 0);
        chk("flack_count", s_count, 0);
        chk("flack_valid", 32'(s_valid), 0);
        // misaligned PC
        tick(0, 0, 1, 0, 32'h0040_0002);
        tick(0, 1, 0, 32'h6666_6666, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        if (MIS) begin
            chk("mis_valid", 32'(s_valid), 1);
            chk("mis_fault", 32'(s_fault), 1);
            chk("mis_pc", s_pc, 32'h0040_0002);
            chk("mis_req", 32'(s_req), 0);
        end else begin
            chk("mis_req", 32'(s_req), 1);
            chk("mis_addr", s_addr, 32'h0040_0002);
        end
        // randomized traffic
        rlvl = 6;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rlvl = int'($urandom_range(0, 8));
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 5 == 0) t = t | 32'(($urandom % 3) + 1);
            tick(($urandom % 8) < rlvl, m_busy && ($urandom % 3 == 0), $urandom % 40 == 0, $urandom, t);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch_buffer.md
# ifetch_buffer

Instruction-fetch stage sitting directly downstream of the program counter register. It samples the current PC address, runs a single-outstanding request/acknowledge transaction against instruction memory, and queues returned instructions with their PC in a small show-ahead FIFO for decode. It tells the PC stage when to advance and supports a flush for branch/jump redirects.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_addr  in  32  current PC from the PC stage
- pc_advance  out  1  one-cycle pulse: PC stage loads its next address at this edge
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address, stable while imem_req=1
- imem_ack  in  1  memory accepts and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- flush  in  1  redirect: discard queued and in-flight instructions
- dec_valid  out  1  head entry valid
- dec_ready  in  1  decode consumes head when dec_valid=1
- dec_instr  out  32  head instruction
- dec_pc  out  32  head PC
- dec_fault  out  1  head entry is a fetch fault (see Configuration)
- fifo_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- States: IDLE, REQ, DROP, HALT.
- IDLE: if flush=0 and fifo_count < DEPTH (counting a pop in the same cycle is NOT allowed — uses registered count), capture pc_addr into imem_addr, go REQ.
- REQ: imem_req=1. On imem_ack with flush=0: push {imem_rdata, imem_addr, fault=0}, pulse pc_advance, go IDLE. No ack: stay.
- DROP: imem_req=1, imem_addr held. On imem_ack: data discarded, no pc_advance, go IDLE.
- imem_req = (state==REQ)||(state==DROP), decoded from state; never deasserts before ack.
- FIFO: show-ahead; dec_* driven from head storage; dec_valid = (fifo_count≠0) && !flush.
- Pop when dec_valid && dec_ready. Push and pop same cycle: count unchanged, both take effect.
- flush priority over push and pop: FIFO emptied (count→0, pointers reset). State REQ without ack → DROP; REQ with ack in flush cycle → IDLE, data discarded, no pc_advance; DROP unchanged; IDLE and HALT → IDLE.
- Pointers wrap modulo DEPTH; no overflow possible since requests issue only with a free slot.
- Reset: state=IDLE, FIFO empty, fifo_count=0, dec_valid=0, dec_fault=0, imem_req=0, imem_addr=0, pc_advance=0, dec_instr=0, dec_pc=0. Reset mid-transaction abandons the request; memory must tolerate req dropping on reset.

## Timing
- pc_addr sampled on IDLE→REQ edge; imem_req asserted the following cycle.
- Zero-wait memory (ack in first REQ cycle): entry visible on dec_valid 2 cycles after IDLE sampling.
- pc_advance coincides with the ack edge; PC value is new the next cycle, when IDLE samples it.
- Sustained throughput: one instruction per 2 cycles with zero-wait memory; N wait cycles → one per N+2.
- Decode backpressure: fetching stops when fifo_count=DEPTH; resumes in the cycle after a pop.
- flush effective the same edge; first post-flush request issues ≥1 cycle later (≥2 if in DROP).

## Configuration
- IFB_MISALIGN_CHECK_EN defined: in IDLE, if pc_addr[1:0]≠0 and a slot is free, no memory request; push {instr=0, pc=pc_addr, fault=1}, no pc_advance, go HALT. HALT issues nothing until flush (or reset). dec_fault reflects the head entry's fault bit.
- Undefined: no check; pc_addr used as is; fault storage omitted; dec_fault tied 0; HALT unreachable.

## Test plan
- Reset then pc_addr=0x00400000, zero-wait memory returning 0x8C080004 → imem_req cycle 1, push on ack, dec_valid cycle 2 with dec_instr=0x8C080004, dec_pc=0x00400000, one pc_advance pulse.
- dec_ready=0, DEPTH=2, PC stepping by 4 → exactly 2 entries (0x00400000, 0x00400004), fifo_count=2, imem_req stays 0; raise dec_ready → entries pop in order, fetching resumes.
- imem_ack delayed 3 cycles → imem_req and imem_addr stable for 4 cycles, single push, single pc_advance.
- flush while in REQ with 1 entry queued, ack 2 cycles later → fifo_count=0 same edge, DROP held until ack, rdata discarded, no pc_advance, next request uses new pc_addr=0x00400100.
- Simultaneous push and pop at fifo_count=1 → count stays 1, order preserved; flush with ack same cycle → nothing queued, pc_advance=0.
- With IFB_MISALIGN_CHECK_EN: pc_addr=0x00400002 → dec_valid=1, dec_fault=1, dec_pc=0x00400002, no imem_req until flush; without macro: request issued with imem_addr=0x00400002.
